// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC and the IF/ID latch, and applies stalls, branch flushes,
// HALT drain/stop and single-step gating.
module fetch_stage_ctrl #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  INSN_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  DRAIN_CYCLES = 4,
  parameter logic [5:0]          HALT_OPCODE  = 6'b010101
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_PC_WRITE,
  input  logic                  I_IFID_WRITE,
  input  logic                  I_BRANCH_TAKEN,
  input  logic [PC_WIDTH-1:0]   I_BRANCH_TARGET,
  input  logic                  I_STEP_MODE,
  input  logic                  I_STEP,
  input  logic [INSN_WIDTH-1:0] I_IMEM_DATA,
  output logic [PC_WIDTH-1:0]   O_IMEM_ADDR,
  output logic [INSN_WIDTH-1:0] O_IFID_INSN,
  output logic [PC_WIDTH-1:0]   O_IFID_PC4,
  output logic                  O_IFID_VALID,
  output logic                  O_HALTED,
  output logic [31:0]           O_FETCH_COUNT
);

  localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                  state_reg;
  logic [PC_WIDTH-1:0]     pc_reg;
  logic [INSN_WIDTH-1:0]   insn_reg;
  logic [PC_WIDTH-1:0]     pc4_reg;
  logic                    valid_reg;
  logic                    halted_reg;
  logic [31:0]             count_reg;
  logic [CW-1:0]           drain_cnt_reg;

  logic [PC_WIDTH-1:0]     pc_plus4;
  logic                    fetch_is_halt;
  logic                    step_blocked;

  assign pc_plus4      = pc_reg + PC_WIDTH'(4);
  assign fetch_is_halt = (I_IMEM_DATA[INSN_WIDTH-1 -: 6] == HALT_OPCODE);
  assign step_blocked  = I_STEP_MODE && !I_STEP;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= RUN;
      pc_reg        <= RESET_PC;
      insn_reg      <= '0;
      pc4_reg       <= '0;
      valid_reg     <= 1'b0;
      halted_reg    <= 1'b0;
      count_reg     <= '0;
      drain_cnt_reg <= '0;
    end else if (I_BRANCH_TAKEN && state_reg != HALTED) begin
      // Redirect wins over stalls and step gating, and cancels any pending HALT drain.
      state_reg <= RUN;
      pc_reg    <= I_BRANCH_TARGET;
      insn_reg  <= '0;
      pc4_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        HALTED: begin
        end
        DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + CW'(1);
          if (drain_cnt_reg == CW'(DRAIN_CYCLES - 1)) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        default: begin
          if (step_blocked) begin
            insn_reg  <= '0;
            pc4_reg   <= pc_plus4;
            valid_reg <= 1'b0;
          end else begin
            if (I_IFID_WRITE) begin
              insn_reg  <= I_IMEM_DATA;
              pc4_reg   <= pc_plus4;
              valid_reg <= 1'b1;
              count_reg <= count_reg + 32'd1;
            end
            // A latched HALT freezes the PC on the HALT itself and starts the drain.
            if (I_IFID_WRITE && fetch_is_halt) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= '0;
            end else if (I_PC_WRITE) begin
              pc_reg <= pc_plus4;
            end
          end
        end
      endcase
    end
  end

  assign O_IMEM_ADDR   = pc_reg;
  assign O_IFID_INSN   = insn_reg;
  assign O_IFID_PC4    = pc4_reg;
  assign O_IFID_VALID  = valid_reg;
  assign O_HALTED      = halted_reg;
  assign O_FETCH_COUNT = count_reg;

endmodule
